// File: rtl/wb_regfile_hilo_pkg.sv
// Shared widths and read-source selection for the write-back register file.
// Imported by the GPR/HI/LO commit block and its HI/LO sub-register.
package wb_regfile_hilo_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_REG    = 2'd2
    } read_src_e;

    // Read-port priority: reset, disable and r0 all read zero ahead of the bypass.
    function automatic read_src_e read_src(
        input logic rst,
        input logic re,
        input logic addr_zero,
        input logic wb_hit
    );
        if (rst || !re || addr_zero) begin
            return SRC_ZERO;
        end
        if (wb_hit) begin
            return SRC_BYPASS;
        end
        return SRC_REG;
    endfunction

endpackage

// File: rtl/wb_regfile_hilo_hilo_reg.sv
// Registered HI/LO pair; both halves are always written together.
// Synchronous active-high reset clears both to zero.
module hilo_reg
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (we) begin
            hi_o <= hi_i;
            lo_o <= lo_i;
        end
    end

endmodule

// File: rtl/wb_regfile_hilo.sv
// Write-back commit: 32-entry GPR file with WB->ID bypass read ports,
// plus the HI/LO special registers presented to EX.
module wb_regfile_hilo
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    read_src_e src1;
    read_src_e src2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    assign src1 = read_src(rst, re1, raddr1 == '0,
                           wb_wreg && (wb_wd == raddr1));
    assign src2 = read_src(rst, re2, raddr2 == '0,
                           wb_wreg && (wb_wd == raddr2));

    always_comb begin
        rdata1 = '0;
        unique case (src1)
            SRC_BYPASS: rdata1 = wb_wdata;
            SRC_REG:    rdata1 = regs[raddr1];
            default:    rdata1 = '0;
        endcase
    end

    always_comb begin
        rdata2 = '0;
        unique case (src2)
            SRC_BYPASS: rdata2 = wb_wdata;
            SRC_REG:    rdata2 = regs[raddr2];
            default:    rdata2 = '0;
        endcase
    end

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we   (wb_whilo),
        .hi_i (wb_hi),
        .lo_i (wb_lo),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Scoreboard bench for wb_regfile_hilo: directed scenarios then random traffic,
// expectations from an array-based architectural model.
module tb_wb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    wb_regfile_hilo dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .wb_whilo (wb_whilo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          failures;
    int          cyc;
    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    // Architectural state update for the inputs held across this edge.
    function automatic void model_commit();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) m_regs[wb_wd] = wb_wdata;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'h0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return m_regs[a];
    endfunction

    task automatic cycle(
        input logic        r,
        input logic        wreg,
        input logic [4:0]  wd,
        input logic [31:0] wdata,
        input logic        whilo,
        input logic [31:0] h,
        input logic [31:0] l,
        input logic        e1,
        input logic [4:0]  a1,
        input logic        e2,
        input logic [4:0]  a2
    );
        exp_t e;
        @(posedge clk);
        model_commit();
        #1;
        rst = r; wb_wreg = wreg; wb_wd = wd; wb_wdata = wdata;
        wb_whilo = whilo; wb_hi = h; wb_lo = l;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        cyc++;
        e.tag = cyc;
        e.r1  = model_read(e1, a1);
        e.r2  = model_read(e2, a2);
        e.hi  = m_hi;
        e.lo  = m_lo;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int tag,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata1", e.tag, rdata1, e.r1);
            chk("rdata2", e.tag, rdata2, e.r2);
            chk("hi_o", e.tag, hi_o, e.hi);
            chk("lo_o", e.tag, lo_o, e.lo);
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b1; wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
        wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;

        // Reset held while both ports sweep every nonzero address.
        for (int a = 1; a < 32; a++) begin
            cycle(1, 0, 0, 0, 0, 0, 0, 1, 5'(a), 1, 5'(32 - a));
        end

        // Write r5, then read it enabled and disabled.
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 5);

        // Same-cycle bypass on port 2, then from storage on both ports.
        cycle(0, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 1, 7);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7);

        // r0 writes are dropped.
        cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

        // HI/LO write, then hold with different data on the bus.
        cycle(0, 0, 0, 0, 1, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 32'hABCD, 32'h1234, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 32'h9999, 32'h7777, 0, 0, 0, 0);

        // GPR and HI/LO commit together.
        cycle(0, 1, 3, 32'h00001111, 1, 32'h2, 32'h3, 1, 3, 1, 5);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 7);

        // Reset mid-stream drops the concurrent writes.
        cycle(1, 1, 3, 32'hA5A5A5A5, 1, 32'h55, 32'h66, 1, 3, 1, 3);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 5);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 3);

        // Random traffic, with biased address reuse to hit the bypass often.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wd;
            logic [4:0] a1;
            logic [4:0] a2;
            wd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 2) != 0), wd, $urandom(),
                  ($urandom_range(0, 3) == 0), $urandom(), $urandom(),
                  ($urandom_range(0, 5) != 0), a1,
                  ($urandom_range(0, 5) != 0), a2);
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
